// File: rtl/efpga_op_arbiter_if.sv
// rtl/efpga_op_arbiter_if.sv - eFPGA accelerator pin bundle between the arbiter and the eFPGA
interface efpga_op_arbiter_if;
   logic        eFPGA_en_o;
   logic        eFPGA_write_strobe_o;
   logic [31:0] eFPGA_operand_a_o;
   logic [31:0] eFPGA_operand_b_o;
   logic [1:0]  eFPGA_operator_o;
   logic [3:0]  eFPGA_delay_o;
   logic        eFPGA_fpga_done_i;
   logic [31:0] eFPGA_result_a_i;
   logic [31:0] eFPGA_result_b_i;
   logic [31:0] eFPGA_result_c_i;

   modport master (
      output eFPGA_en_o, eFPGA_write_strobe_o, eFPGA_operand_a_o, eFPGA_operand_b_o,
             eFPGA_operator_o, eFPGA_delay_o,
      input  eFPGA_fpga_done_i, eFPGA_result_a_i, eFPGA_result_b_i, eFPGA_result_c_i
   );

   modport slave (
      input  eFPGA_en_o, eFPGA_write_strobe_o, eFPGA_operand_a_o, eFPGA_operand_b_o,
             eFPGA_operator_o, eFPGA_delay_o,
      output eFPGA_fpga_done_i, eFPGA_result_a_i, eFPGA_result_b_i, eFPGA_result_c_i
   );
endinterface

// File: rtl/efpga_op_arbiter.sv
// rtl/efpga_op_arbiter.sv - round-robin sharing of the eFPGA port between r0 and r1; EFPGA_ARB_STATS_EN adds op/timeout counters
module efpga_op_arbiter #(
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        r0_req_i,
   input  logic [31:0] r0_operand_a_i,
   input  logic [31:0] r0_operand_b_i,
   input  logic [1:0]  r0_operator_i,
   input  logic [3:0]  r0_delay_i,
   output logic        r0_gnt_o,
   output logic        r0_done_o,
   output logic        r0_err_o,
   input  logic        r1_req_i,
   input  logic [31:0] r1_operand_a_i,
   input  logic [31:0] r1_operand_b_i,
   input  logic [1:0]  r1_operator_i,
   input  logic [3:0]  r1_delay_i,
   output logic        r1_gnt_o,
   output logic        r1_done_o,
   output logic        r1_err_o,
   output logic [31:0] res_a_o,
   output logic [31:0] res_b_o,
   output logic [31:0] res_c_o,
   output logic        busy_o,
`ifdef EFPGA_ARB_STATS_EN
   output logic [15:0] op_count_o,
   output logic [7:0]  timeout_count_o,
`endif
   efpga_op_arbiter_if.master efpga
);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DELAY, WAIT_DONE, RESP} state_t;

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t     state;
   logic       owner;
   logic       last_grant;
   logic [3:0] dly_cnt;
   logic [7:0] to_cnt;
   logic       pick;

   // winner selection: a lone requester wins, a tie goes to the one not served last
   always_comb begin
      pick = 1'b0;
      if (r0_req_i && r1_req_i) begin
         pick = ~last_grant;
      end else begin
         pick = r1_req_i;
      end
   end

   // operation sequencer; every output is a register written here
   always_ff @(posedge clk) begin
      if (reset) begin
         state                      <= IDLE;
         owner                      <= 1'b0;
         last_grant                 <= 1'b1;
         dly_cnt                    <= '0;
         to_cnt                     <= '0;
         r0_gnt_o                   <= 1'b0;
         r0_done_o                  <= 1'b0;
         r0_err_o                   <= 1'b0;
         r1_gnt_o                   <= 1'b0;
         r1_done_o                  <= 1'b0;
         r1_err_o                   <= 1'b0;
         res_a_o                    <= '0;
         res_b_o                    <= '0;
         res_c_o                    <= '0;
         busy_o                     <= 1'b0;
         efpga.eFPGA_en_o           <= 1'b0;
         efpga.eFPGA_write_strobe_o <= 1'b0;
         efpga.eFPGA_operand_a_o    <= '0;
         efpga.eFPGA_operand_b_o    <= '0;
         efpga.eFPGA_operator_o     <= '0;
         efpga.eFPGA_delay_o        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (r0_req_i || r1_req_i) begin
                  owner                      <= pick;
                  efpga.eFPGA_operand_a_o    <= pick ? r1_operand_a_i : r0_operand_a_i;
                  efpga.eFPGA_operand_b_o    <= pick ? r1_operand_b_i : r0_operand_b_i;
                  efpga.eFPGA_operator_o     <= pick ? r1_operator_i  : r0_operator_i;
                  efpga.eFPGA_delay_o        <= pick ? r1_delay_i     : r0_delay_i;
                  r0_gnt_o                   <= ~pick;
                  r1_gnt_o                   <= pick;
                  efpga.eFPGA_write_strobe_o <= 1'b1;
                  efpga.eFPGA_en_o           <= 1'b1;
                  busy_o                     <= 1'b1;
                  state                      <= ISSUE;
               end
            end
            ISSUE: begin
               r0_gnt_o                   <= 1'b0;
               r1_gnt_o                   <= 1'b0;
               efpga.eFPGA_write_strobe_o <= 1'b0;
               dly_cnt                    <= efpga.eFPGA_delay_o;
               to_cnt                     <= '0;
               state <= (efpga.eFPGA_delay_o != 4'd0) ? WAIT_DELAY : WAIT_DONE;
            end
            WAIT_DELAY: begin
               // done_i is deliberately not looked at while the delay runs
               dly_cnt <= dly_cnt - 4'd1;
               if (dly_cnt == 4'd1) begin
                  state <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               // a done arriving on the timeout cycle still counts as success
               if (efpga.eFPGA_fpga_done_i) begin
                  res_a_o          <= efpga.eFPGA_result_a_i;
                  res_b_o          <= efpga.eFPGA_result_b_i;
                  res_c_o          <= efpga.eFPGA_result_c_i;
                  r0_done_o        <= ~owner;
                  r1_done_o        <= owner;
                  r0_err_o         <= 1'b0;
                  r1_err_o         <= 1'b0;
                  efpga.eFPGA_en_o <= 1'b0;
                  state            <= RESP;
               end else if (to_cnt == TO_LAST) begin
                  res_a_o          <= '0;
                  res_b_o          <= '0;
                  res_c_o          <= '0;
                  r0_done_o        <= ~owner;
                  r1_done_o        <= owner;
                  r0_err_o         <= ~owner;
                  r1_err_o         <= owner;
                  efpga.eFPGA_en_o <= 1'b0;
                  state            <= RESP;
               end else begin
                  to_cnt <= to_cnt + 8'd1;
               end
            end
            RESP: begin
               r0_done_o  <= 1'b0;
               r1_done_o  <= 1'b0;
               r0_err_o   <= 1'b0;
               r1_err_o   <= 1'b0;
               busy_o     <= 1'b0;
               last_grant <= owner;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef EFPGA_ARB_STATS_EN
   // per-RESP tallies of completed operations and timeouts, sticking at all-ones
   always_ff @(posedge clk) begin
      if (reset) begin
         op_count_o      <= '0;
         timeout_count_o <= '0;
      end else if (state == RESP) begin
         if (op_count_o != 16'hFFFF) begin
            op_count_o <= op_count_o + 16'd1;
         end
         if ((r0_err_o || r1_err_o) && (timeout_count_o != 8'hFF)) begin
            timeout_count_o <= timeout_count_o + 8'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_efpga_op_arbiter.sv
// tb/tb_efpga_op_arbiter.sv - scoreboard bench for efpga_op_arbiter with a behavioural eFPGA responder
module tb_efpga_op_arbiter;

   localparam int TO = 64;

   typedef struct {
      int          who;
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  op;
      logic [3:0]  d;
      int          l;    // done pulse l cycles after strobe; 0 = held high; 255 = never
      int          s;    // expected strobe cycle
   } op_t;

   typedef struct {
      int          who;
      logic        err;
      logic [95:0] res;
      int          cyc;
   } rsp_t;

   logic        clk;
   logic        reset;
   logic        r0_req, r1_req;
   logic [31:0] r0_a, r0_b, r1_a, r1_b;
   logic [1:0]  r0_op, r1_op;
   logic [3:0]  r0_dly, r1_dly;
   logic        r0_gnt, r0_done, r0_err, r1_gnt, r1_done, r1_err;
   logic [31:0] res_a, res_b, res_c;
   logic        busy;
`ifdef EFPGA_ARB_STATS_EN
   logic [15:0] op_count;
   logic [7:0]  timeout_count;
`endif

   efpga_op_arbiter_if efpga();

   efpga_op_arbiter #(.TIMEOUT(TO)) dut (
      .clk            (clk),
      .reset          (reset),
      .r0_req_i       (r0_req),
      .r0_operand_a_i (r0_a),
      .r0_operand_b_i (r0_b),
      .r0_operator_i  (r0_op),
      .r0_delay_i     (r0_dly),
      .r0_gnt_o       (r0_gnt),
      .r0_done_o      (r0_done),
      .r0_err_o       (r0_err),
      .r1_req_i       (r1_req),
      .r1_operand_a_i (r1_a),
      .r1_operand_b_i (r1_b),
      .r1_operator_i  (r1_op),
      .r1_delay_i     (r1_dly),
      .r1_gnt_o       (r1_gnt),
      .r1_done_o      (r1_done),
      .r1_err_o       (r1_err),
      .res_a_o        (res_a),
      .res_b_o        (res_b),
      .res_c_o        (res_c),
      .busy_o         (busy),
`ifdef EFPGA_ARB_STATS_EN
      .op_count_o     (op_count),
      .timeout_count_o(timeout_count),
`endif
      .efpga          (efpga)
   );

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   last_done = 0;
   int   last_grant_m = 1;
   int   m_ops = 0;
   int   m_tos = 0;
   op_t  resp_q[$];
   rsp_t exp_q[$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // what the eFPGA computes for an operation
   function automatic logic [95:0] fres(input op_t o);
      return {o.a + o.b, o.a - o.b, (o.a ^ o.b) + {26'd0, o.op, o.d}};
   endfunction

   function automatic logic [255:0] all_outs();
      return 256'({r0_gnt, r0_done, r0_err, r1_gnt, r1_done, r1_err, res_a, res_b, res_c, busy,
                   efpga.eFPGA_en_o, efpga.eFPGA_write_strobe_o, efpga.eFPGA_operand_a_o,
                   efpga.eFPGA_operand_b_o, efpga.eFPGA_operator_o, efpga.eFPGA_delay_o});
   endfunction

   function automatic op_t mk(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                              input logic [3:0] d, input int l);
      op_t o;
      o.who = 0; o.a = a; o.b = b; o.op = op; o.d = d; o.l = l; o.s = 0;
      return o;
   endfunction

   function automatic op_t rnd_op();
      op_t o;
      int  r;
      o = mk($urandom, $urandom, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 0);
      r = $urandom_range(0, 9);
      if (r < 6)       o.l = $urandom_range(int'(o.d) + 1, int'(o.d) + 8);
      else if (r < 8)  o.l = $urandom_range(1, 20);
      else if (r == 8) o.l = 0;
      else             o.l = 255;
      return o;
   endfunction

   task automatic flush_model();
      exp_q.delete();
      resp_q.delete();
      last_grant_m = 1;
      m_ops = 0;
      m_tos = 0;
      last_done = cyc;
   endtask

   // issue one round: the requesters in mask raise req; the model predicts order, timing and results
   task automatic run_round(input int mask, input op_t o0, input op_t o1, input int gap);
      op_t  ord[$];
      op_t  o;
      rsp_t r;
      int   n, first, budget;
      bit   p0, p1;
      o0.who = 0;
      o1.who = 1;
      repeat (gap) @(negedge clk);
      if (cyc > last_done) chk("idle_busy", busy, 0);
      n = (cyc > last_done) ? cyc : cyc + 1;
      first = (mask == 3) ? 1 - last_grant_m : ((mask == 2) ? 1 : 0);
      if (mask == 3) begin
         if (first == 0) begin ord.push_back(o0); ord.push_back(o1); end
         else            begin ord.push_back(o1); ord.push_back(o0); end
      end else begin
         ord.push_back(first == 1 ? o1 : o0);
      end
      foreach (ord[i]) begin
         o = ord[i];
         o.s = n + 1;
         r.who = o.who;
         if (o.l == 0) begin
            r.err = 1'b0; r.cyc = o.s + int'(o.d) + 2;
         end else if (o.l >= int'(o.d) + 1 && o.l <= int'(o.d) + TO) begin
            r.err = 1'b0; r.cyc = o.s + o.l + 1;
         end else begin
            r.err = 1'b1; r.cyc = o.s + int'(o.d) + TO + 1;
         end
         r.res = r.err ? 96'd0 : fres(o);
         resp_q.push_back(o);
         exp_q.push_back(r);
         last_grant_m = o.who;
         m_ops++;
         if (r.err) m_tos++;
         n = r.cyc + 1;
      end
      p0 = (mask & 1) != 0;
      p1 = (mask & 2) != 0;
      if (p0) begin r0_req = 1'b1; r0_a = o0.a; r0_b = o0.b; r0_op = o0.op; r0_dly = o0.d; end
      if (p1) begin r1_req = 1'b1; r1_a = o1.a; r1_b = o1.b; r1_op = o1.op; r1_dly = o1.d; end
      budget = 0;
      while ((p0 || p1) && budget < 400) begin
         @(negedge clk);
         budget++;
         // after the grant the inputs are free to change, and req may even drop
         if (r0_gnt) begin
            r0_a = $urandom; r0_b = $urandom; r0_op = 2'($urandom); r0_dly = 4'($urandom);
            if ($urandom_range(0, 1) == 1) r0_req = 1'b0;
         end
         if (r1_gnt) begin
            r1_a = $urandom; r1_b = $urandom; r1_op = 2'($urandom); r1_dly = 4'($urandom);
            if ($urandom_range(0, 1) == 1) r1_req = 1'b0;
         end
         if (r0_done) begin r0_req = 1'b0; p0 = 1'b0; last_done = cyc; end
         if (r1_done) begin r1_req = 1'b0; p1 = 1'b0; last_done = cyc; end
      end
      if (p0 || p1) begin
         checks++;
         errors++;
         $display("FAIL round_timeout: pending r0=%0d r1=%0d, required none after %0d cycles", p0, p1, budget);
         reset = 1'b1; r0_req = 1'b0; r1_req = 1'b0;
         repeat (2) @(negedge clk);
         reset = 1'b0;
         flush_model();
      end
   endtask

   // eFPGA responder: checks each issue against the scoreboard and plays back its done pattern
   initial begin
      op_t cur;
      int  pcnt, hcnt;
      bit  prev_strobe, drive;
      pcnt = 0; hcnt = 0; prev_strobe = 0;
      cur = mk(0, 0, 0, 0, 255);
      efpga.eFPGA_fpga_done_i = 1'b0;
      efpga.eFPGA_result_a_i = '0;
      efpga.eFPGA_result_b_i = '0;
      efpga.eFPGA_result_c_i = '0;
      forever begin
         @(negedge clk);
         drive = 1'b0;
         if (reset) begin
            pcnt = 0; hcnt = 0; prev_strobe = 0;
         end else begin
            if (hcnt > 0) begin
               hcnt--; drive = 1'b1;
            end else if (pcnt > 0) begin
               pcnt--;
               if (pcnt == 0) drive = 1'b1;
            end
            if (prev_strobe)
               chk("strobe_gnt_width", {efpga.eFPGA_write_strobe_o, r0_gnt, r1_gnt}, 0);
            prev_strobe = efpga.eFPGA_write_strobe_o;
            if (efpga.eFPGA_write_strobe_o) begin
               if (resp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_issue: strobe with no pending request at cycle %0d", cyc);
               end else begin
                  cur = resp_q.pop_front();
                  chk("issue_operands", {efpga.eFPGA_operand_a_o, efpga.eFPGA_operand_b_o,
                      efpga.eFPGA_operator_o, efpga.eFPGA_delay_o}, {cur.a, cur.b, cur.op, cur.d});
                  chk("issue_grant", {r1_gnt, r0_gnt}, (cur.who == 1) ? 2'b10 : 2'b01);
                  chk("issue_cycle", cyc, cur.s);
                  chk("issue_en_busy", {efpga.eFPGA_en_o, busy}, 2'b11);
                  pcnt = 0; hcnt = 0;
                  if (cur.l == 0)        hcnt = int'(cur.d) + 1;
                  else if (cur.l < 255)  pcnt = cur.l;
               end
            end
         end
         efpga.eFPGA_fpga_done_i = drive;
         if (drive)
            {efpga.eFPGA_result_a_i, efpga.eFPGA_result_b_i, efpga.eFPGA_result_c_i} = fres(cur);
         else
            {efpga.eFPGA_result_a_i, efpga.eFPGA_result_b_i, efpga.eFPGA_result_c_i} = {$urandom, $urandom, $urandom};
      end
   end

   // response monitor: pops the scoreboard whenever a done pulse appears
   initial begin
      rsp_t e;
      forever begin
         @(negedge clk);
         if (!reset && (r0_done || r1_done)) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: r0_done=%0d r1_done=%0d with empty scoreboard", r0_done, r1_done);
            end else begin
               e = exp_q.pop_front();
               chk("done_owner", {r1_done, r0_done}, (e.who == 1) ? 2'b10 : 2'b01);
               chk("done_cycle", cyc, e.cyc);
               chk("done_err", {r1_err, r0_err}, e.err ? ((e.who == 1) ? 2'b10 : 2'b01) : 2'b00);
               chk("done_results", {res_a, res_b, res_c}, e.res);
               chk("done_en_low", efpga.eFPGA_en_o, 0);
            end
         end
      end
   end

   initial begin
      op_t x, y;
      reset = 1'b1;
      r0_req = 1'b0; r0_a = '0; r0_b = '0; r0_op = '0; r0_dly = '0;
      r1_req = 1'b0; r1_a = '0; r1_b = '0; r1_op = '0; r1_dly = '0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", all_outs(), 0);
`ifdef EFPGA_ARB_STATS_EN
      chk("reset_stats", {op_count, timeout_count}, 0);
`endif
      reset = 1'b0;
      flush_model();

      // single op: a=5 b=7 op=2 delay=0, done 3 cycles after strobe, res_a = 12
      x = mk(32'd5, 32'd7, 2'd2, 4'd0, 3);
      run_round(1, x, x, 1);
      // delay 4 with done held high: completes 6 cycles after strobe
      y = mk($urandom, $urandom, 2'd1, 4'd4, 0);
      run_round(2, y, y, 2);
      // timeout on r0, then a normal r1 op
      x = mk($urandom, $urandom, 2'd3, 4'd0, 255);
      run_round(1, x, x, 1);
      y = mk($urandom, $urandom, 2'd0, 4'd1, 5);
      run_round(2, y, y, 1);

      // reset in the middle of WAIT_DONE
      @(negedge clk);
      x = mk($urandom, $urandom, 2'd1, 4'd2, 255);
      x.s = cyc + 1;
      resp_q.push_back(x);
      r0_req = 1'b1; r0_a = x.a; r0_b = x.b; r0_op = x.op; r0_dly = x.d;
      repeat (int'(x.d) + 12) @(negedge clk);
      reset = 1'b1;
      r0_req = 1'b0;
      @(negedge clk);
      chk("midop_reset_outputs", all_outs(), 0);
      chk("midop_reset_busy", busy, 0);
`ifdef EFPGA_ARB_STATS_EN
      chk("midop_reset_stats", {op_count, timeout_count}, 0);
`endif
      reset = 1'b0;
      flush_model();

      // both requesting continuously: r0 first, then strict alternation
      x = mk($urandom, $urandom, 2'd0, 4'd0, 1);
      y = mk($urandom, $urandom, 2'd1, 4'd0, 1);
      run_round(3, x, y, 2);
      run_round(3, x, y, 0);
      x = mk($urandom, $urandom, 2'd2, 4'd3, 255);
      run_round(1, x, x, 1);
      @(negedge clk);
`ifdef EFPGA_ARB_STATS_EN
      chk("stats_op_count", op_count, m_ops);
      chk("stats_timeout_count", timeout_count, m_tos);
`endif

      for (int i = 0; i < 40; i++) begin
         x = rnd_op();
         y = rnd_op();
         run_round($urandom_range(1, 3), x, y, $urandom_range(0, 3));
      end
      repeat (2) @(negedge clk);
      chk("scoreboard_drained", {32'(exp_q.size()), 32'(resp_q.size())}, 0);
`ifdef EFPGA_ARB_STATS_EN
      chk("final_op_count", op_count, m_ops);
      chk("final_timeout_count", timeout_count, m_tos);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
